// File: rtl/frame_swap_ctrl.sv
// Double-buffered frame capture controller: steers camera writes into the back
// buffer and swaps buffers in display vblank. Optional macro: FRAME_SWAP_TIMEOUT_EN.
module frame_swap_ctrl #(
  parameter int CNT_W = 8
`ifdef FRAME_SWAP_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
`endif
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             ack,
  input  logic             cam_vsync,
  input  logic             cam_we_in,
  input  logic             disp_vblank,
  output logic             image_sel,
  output logic             we_0,
  output logic             we_1,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SWAP    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             vsync_prev_reg;
  logic             vsync_fall;
  logic             vsync_rise;
  logic             image_sel_reg;
  logic [CNT_W-1:0] frame_cnt_reg;
  logic             swap_fire;
  logic             timeout_hit;

  assign vsync_fall = vsync_prev_reg & ~cam_vsync;
  assign vsync_rise = ~vsync_prev_reg & cam_vsync;

`ifdef FRAME_SWAP_TIMEOUT_EN
  logic [23:0] timeout_cnt_reg;
  logic        err_reg;

  assign timeout_hit = ((state_reg == ST_WAIT_VS) || (state_reg == ST_CAPTURE)) &&
                       (timeout_cnt_reg == (TIMEOUT_CYCLES - 24'd1));

  // Counter restarts whenever a new capture attempt begins in WAIT_VS.
  always_ff @(posedge clock) begin
    if (rst) begin
      timeout_cnt_reg <= 24'd0;
      err_reg         <= 1'b0;
    end else begin
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
      if ((state_next == ST_WAIT_VS) && (state_reg != ST_WAIT_VS)) begin
        timeout_cnt_reg <= 24'd0;
      end else if ((state_reg == ST_WAIT_VS) || (state_reg == ST_CAPTURE)) begin
        timeout_cnt_reg <= timeout_cnt_reg + 24'd1;
      end
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      vsync_prev_reg <= 1'b1;
      image_sel_reg  <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      vsync_prev_reg <= cam_vsync;
      if (swap_fire) begin
        image_sel_reg <= ~image_sel_reg;
        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    swap_fire  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (timeout_hit) begin
          state_next = ST_IDLE;
        end else if (vsync_fall) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (timeout_hit) begin
          state_next = ST_IDLE;
        end else if (vsync_rise) begin
          state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
        if (disp_vblank) begin
          swap_fire  = 1'b1;
          state_next = cont ? ST_WAIT_VS : ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Writes only ever reach the buffer not currently on screen.
  always_comb begin
    we_0 = 1'b0;
    we_1 = 1'b0;
    busy = (state_reg != ST_IDLE);
    done = (state_reg == ST_DONE);
    if (state_reg == ST_CAPTURE) begin
      we_0 = cam_we_in & image_sel_reg;
      we_1 = cam_we_in & ~image_sel_reg;
    end
  end

  assign image_sel = image_sel_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Randomised bench for frame_swap_ctrl against a frame-level model of buffer
// selection, swap count and per-buffer write totals.
module tb_frame_swap_ctrl;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       ack = 1'b0;
  logic       cam_vsync = 1'b1;
  logic       cam_we_in = 1'b0;
  logic       disp_vblank = 1'b0;
  logic       image_sel;
  logic       we_0;
  logic       we_1;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  // Observed activity, accumulated by the monitor only.
  int obs_we0 = 0;
  int obs_we1 = 0;
  int mon_bad = 0;
  int done_seen = 0;
  int idle_seen = 0;

  // Frame-level model.
  bit model_sel = 1'b0;
  int model_cnt = 0;
  int exp_we0 = 0;
  int exp_we1 = 0;

  always #5 clock = ~clock;

  frame_swap_ctrl #(
    .CNT_W(8)
`ifdef FRAME_SWAP_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(24'd16)
`endif
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .ack        (ack),
    .cam_vsync  (cam_vsync),
    .cam_we_in  (cam_we_in),
    .disp_vblank(disp_vblank),
    .image_sel  (image_sel),
    .we_0       (we_0),
    .we_1       (we_1),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .frame_cnt  (frame_cnt)
  );

  always @(negedge clock) begin
    if (we_0) obs_we0++;
    if (we_1) obs_we1++;
    if ((we_0 && we_1) || (we_0 && !image_sel) || (we_1 && image_sel)) mon_bad++;
    if (done) done_seen++;
    if (!busy) idle_seen++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0; cont = 1'b0;
    cam_we_in = 1'b0; disp_vblank = 1'b0; cam_vsync = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_sel = 1'b0;
    model_cnt = 0;
  endtask

  // One camera frame starting in WAIT_VS with vsync high; ends just after the swap.
  task automatic run_frame(input int npix, input bit cont_v, input bit noise);
    int pre;
    int gap;
    int dly;
    cont = cont_v;
    pre = $urandom_range(0, 3);
    repeat (pre) begin
      cam_we_in = noise & $urandom_range(0, 1);
      start = noise & $urandom_range(0, 1);
      ack = noise & $urandom_range(0, 1);
      tick();
    end
    cam_we_in = 1'b0; start = 1'b0; ack = 1'b0;
    cam_vsync = 1'b0;
    tick();
    for (int p = 0; p < npix; p++) begin
      cam_we_in = 1'b1;
      start = noise & $urandom_range(0, 1);
      ack = noise & $urandom_range(0, 1);
      tick();
      cam_we_in = 1'b0; start = 1'b0; ack = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
    end
    cam_vsync = 1'b1;
    tick();
    dly = $urandom_range(0, 3);
    repeat (dly) begin
      cam_we_in = noise & $urandom_range(0, 1);
      tick();
    end
    cam_we_in = 1'b0;
    @(negedge clock);
    checks++;
    if (image_sel !== model_sel) begin
      failures++;
      $display("FAIL pre_swap_sel got=%0b exp=%0b", image_sel, model_sel);
    end
    disp_vblank = 1'b1;
    tick();
    disp_vblank = 1'b0;
    if (model_sel) exp_we0 += npix;
    else exp_we1 += npix;
    model_sel = ~model_sel;
    model_cnt++;
    @(negedge clock);
    checks++;
    if (image_sel !== model_sel) begin
      failures++;
      $display("FAIL swap_sel frame=%0d got=%0b exp=%0b", model_cnt, image_sel, model_sel);
    end
    checks++;
    if (frame_cnt !== 8'(model_cnt)) begin
      failures++;
      $display("FAIL swap_cnt got=%0d exp=%0d", frame_cnt, 8'(model_cnt));
    end
    checks++;
    if (done !== !cont_v || busy !== 1'b1) begin
      failures++;
      $display("FAIL post_swap_state done=%0b busy=%0b exp_done=%0b exp_busy=1", done, busy, !cont_v);
    end
    checks++;
    if (obs_we0 != exp_we0 || obs_we1 != exp_we1) begin
      failures++;
      $display("FAIL write_totals we0=%0d we1=%0d exp_we0=%0d exp_we1=%0d", obs_we0, obs_we1, exp_we0, exp_we1);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    start = 1'b1; cam_we_in = 1'b1; ack = 1'b1; disp_vblank = 1'b1; cont = 1'b1;
    tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%0b done=%0b exp=0/0", busy, done);
    end
    checks++;
    if (image_sel !== 1'b0 || frame_cnt !== 8'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values sel=%0b cnt=%0d err=%0b exp=0/0/0", image_sel, frame_cnt, err);
    end
    checks++;
    if (we_0 !== 1'b0 || we_1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_we we0=%0b we1=%0b exp=0/0", we_0, we_1);
    end
    start = 1'b0; cam_we_in = 1'b0; ack = 1'b0; disp_vblank = 1'b0; cont = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int b0;
    int b1;
    do_reset();
    b0 = obs_we0; b1 = obs_we1;
    start = 1'b1; tick(); start = 1'b0;
    run_frame(4, 1'b0, 1'b0);
    checks++;
    if (obs_we1 - b1 != 4 || obs_we0 - b0 != 0) begin
      failures++;
      $display("FAIL single_we we0=%0d we1=%0d exp=0/4", obs_we0 - b0, obs_we1 - b1);
    end
    checks++;
    if (image_sel !== 1'b1 || frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_swap sel=%0b cnt=%0d exp=1/1", image_sel, frame_cnt);
    end
    repeat (3) begin
      tick();
      @(negedge clock);
      checks++;
      if (done !== 1'b1) begin
        failures++;
        $display("FAIL single_done_hold got=%0b exp=1", done);
      end
    end
    ack = 1'b1; tick(); ack = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_ack done=%0b busy=%0b exp=0/0", done, busy);
    end
  endtask

  task automatic test_continuous();
    int d0;
    int i0;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clock);
    d0 = done_seen; i0 = idle_seen;
    for (int f = 0; f < 3; f++) run_frame($urandom_range(1, 10), 1'b1, 1'b0);
    checks++;
    if (image_sel !== 1'b1 || frame_cnt !== 8'd3) begin
      failures++;
      $display("FAIL cont_result sel=%0b cnt=%0d exp=1/3", image_sel, frame_cnt);
    end
    checks++;
    if (done_seen != d0 || idle_seen != i0) begin
      failures++;
      $display("FAIL cont_flags done_cycles=%0d idle_cycles=%0d exp=0/0", done_seen - d0, idle_seen - i0);
    end
  endtask

  task automatic test_vsync_low_start();
    do_reset();
    cam_vsync = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) begin
      cam_we_in = 1'b1; tick();
      cam_we_in = 1'b0; tick();
    end
    @(negedge clock);
    checks++;
    if (obs_we0 != exp_we0 || obs_we1 != exp_we1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL low_vsync_nowrite we0=%0d we1=%0d busy=%0b exp=%0d/%0d/1", obs_we0, obs_we1, busy, exp_we0, exp_we1);
    end
    cam_vsync = 1'b1;
    repeat (2) tick();
    run_frame($urandom_range(1, 8), 1'b0, 1'b1);
    checks++;
    if (frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL start_in_capture cnt=%0d exp=1", frame_cnt);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset_capture();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    cam_vsync = 1'b0; tick();
    cam_we_in = 1'b1; tick();
    rst = 1'b1;
    @(negedge clock);
    checks++;
    if (we_1 !== 1'b1) begin
      failures++;
      $display("FAIL capture_we_zero_latency we1=%0b exp=1", we_1);
    end
    tick();
    exp_we1 += 2;
    model_sel = 1'b0;
    model_cnt = 0;
    @(negedge clock);
    checks++;
    if (we_1 !== 1'b0 || we_0 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_capture we0=%0b we1=%0b busy=%0b exp=0/0/0", we_0, we_1, busy);
    end
    checks++;
    if (image_sel !== 1'b0 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_in_capture_regs sel=%0b cnt=%0d exp=0/0", image_sel, frame_cnt);
    end
    rst = 1'b0; cam_we_in = 1'b0; cam_vsync = 1'b1;
    tick();
    @(negedge clock);
    checks++;
    if (obs_we0 != exp_we0 || obs_we1 != exp_we1) begin
      failures++;
      $display("FAIL rst_capture_totals we0=%0d we1=%0d exp=%0d/%0d", obs_we0, obs_we1, exp_we0, exp_we1);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
`ifdef FRAME_SWAP_TIMEOUT_EN
    repeat (15) tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early busy=%0b err=%0b exp=1/0", busy, err);
    end
    tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || image_sel !== 1'b0 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL timeout_abort busy=%0b err=%0b sel=%0b cnt=%0d exp=0/1/0/0", busy, err, image_sel, frame_cnt);
    end
`else
    repeat (40) tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout busy=%0b err=%0b done=%0b exp=1/0/0", busy, err, done);
    end
`endif
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    cont = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int f = 0; f < 257; f++) run_frame($urandom_range(0, 2), 1'b1, 1'b0);
    checks++;
    if (frame_cnt !== 8'd1 || image_sel !== 1'b1) begin
      failures++;
      $display("FAIL wrap cnt=%0d sel=%0b exp=1/1", frame_cnt, image_sel);
    end
    do_reset();
  endtask

  task automatic test_random();
    int nf;
    int hold;
    do_reset();
    for (int it = 0; it < 15; it++) begin
      start = 1'b1; ack = $urandom_range(0, 1);
      tick();
      start = 1'b0; ack = 1'b0;
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) run_frame($urandom_range(0, 10), (f != nf - 1), 1'b1);
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        start = $urandom_range(0, 1);
        tick();
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL rand_done_hold iter=%0d got=%0b exp=1", it, done);
        end
      end
      ack = 1'b1; start = $urandom_range(0, 1);
      tick();
      ack = 1'b0; start = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL rand_ack_idle iter=%0d busy=%0b exp=0", it, busy);
      end
    end
  endtask

  task automatic test_monitor();
    checks++;
    if (mon_bad != 0) begin
      failures++;
      $display("FAIL front_buffer_write cycles=%0d exp=0", mon_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_vsync_low_start();
    test_reset_capture();
    test_timeout();
    test_random();
    test_wrap();
    test_monitor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_swap_ctrl.md
FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 24'd1_000_000, cycles allowed in WAIT_VS plus CAPTURE before abort (timeout build only).
REQ-002 Parameter: CNT_W, 8, width of frame_cnt.
REQ-003 Port: clock  in  1  single clock for all logic; capture and display signals arrive pre-synchronised.
REQ-004 Port: rst  in  1  synchronous reset, active-high.
REQ-005 Port: start  in  1  one-cycle request to capture one frame.
REQ-006 Port: cont  in  1  level; 1 = re-arm automatically after each swap.
REQ-007 Port: ack  in  1  acknowledges done.
REQ-008 Port: cam_vsync  in  1  camera vsync, high during camera vertical blank.
REQ-009 Port: cam_we_in  in  1  pixel write strobe from the capture block.
REQ-010 Port: disp_vblank  in  1  display vertical blank (~video_on at frame end).
REQ-011 Port: image_sel  out  1  buffer being displayed; back buffer = ~image_sel.
REQ-012 Port: we_0, we_1  out  1 each  gated write enables to buffer 0 and buffer 1.
REQ-013 Port: busy  out  1  high in any state except IDLE.
REQ-014 Port: done  out  1  high in DONE.
REQ-015 Port: err  out  1  sticky timeout flag (0 when macro absent).
REQ-016 Port: frame_cnt  out  CNT_W  completed swaps, wraps modulo 2^CNT_W.

Function
REQ-017 States: IDLE, WAIT_VS, CAPTURE, SWAP, DONE; encoding is free; there are no unreachable states and no latches.
REQ-018 IDLE: start=1 -> WAIT_VS next cycle; start is ignored in every other state.
REQ-019 vsync edges come from a registered copy: fall = prev&~cur, rise = ~prev&cur; the prev register resets to 1.
REQ-020 WAIT_VS: a vsync fall moves to CAPTURE; the first line of the frame is therefore never partial.
REQ-021 CAPTURE: we_0 = cam_we_in&(image_sel==1), we_1 = cam_we_in&(image_sel==0), combinational with zero latency; a vsync rise moves to SWAP.
REQ-022 Outside CAPTURE: we_0 = we_1 = 0, and the displayed buffer is never written.
REQ-023 SWAP: in the first cycle with disp_vblank=1, image_sel toggles, frame_cnt increments, and the state moves to DONE if cont=0 or WAIT_VS if cont=1; if disp_vblank is already high on entry, the swap occurs in that cycle.
REQ-024 DONE: done=1 until ack=1, then IDLE next cycle; ack outside DONE is ignored; start together with ack is ignored.
REQ-025 image_sel and frame_cnt change only in SWAP.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, image_sel=0, frame_cnt=0, err=0, busy=0, done=0, vsync prev=1, timeout counter=0.
REQ-027 rst asserted mid-CAPTURE: we_0/we_1 are 0 from the following cycle; the partial frame stays in the back buffer and is never displayed.
REQ-028 rst has priority over all other inputs.

Configuration
REQ-029 Macro FRAME_SWAP_TIMEOUT_EN defined: a counter clears on entry to WAIT_VS and increments in WAIT_VS and CAPTURE.
REQ-030 With the macro, when the counter reaches TIMEOUT_CYCLES-1: go to IDLE, set err=1 (sticky until rst), do not swap, and do not change frame_cnt.
REQ-031 Macro absent: no counter logic, err tied 0, WAIT_VS and CAPTURE wait indefinitely.

Verification
REQ-032 Reset, start, vsync fall, 4 cam_we_in pulses, vsync rise, disp_vblank=1 -> exactly 4 we_1 pulses, 0 on we_0; image_sel 0->1; frame_cnt=1; done=1 until ack, then IDLE.
REQ-033 cont=1, 3 camera frames, vblank pulses -> image_sel toggles 3 times (ends 1); frame_cnt=3; done never asserts; busy stays 1.
REQ-034 start while vsync is already low -> no writes until a full vsync rise/fall cycle has passed; start pulses in CAPTURE are ignored (frame_cnt +1 only).
REQ-035 rst asserted during CAPTURE with cam_we_in=1 -> we_1=0 on the next cycle; image_sel=0, frame_cnt=0.
REQ-036 With FRAME_SWAP_TIMEOUT_EN and TIMEOUT_CYCLES=16, start with vsync held high -> at cycle 16 the state is IDLE, err=1, image_sel unchanged; without the macro the block is still in WAIT_VS.
